// File: rtl/neuron_mac_seq_pkg.sv
// Shared types and sign-magnitude helpers for the sequential MAC neuron.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    ACT  = 2'd2,
    OUT  = 2'd3
  } state_e;

  localparam int ACT_STEP = 0;
  localparam int ACT_RELU = 1;

  // Working width for the helpers; any word or accumulator up to this size fits.
  localparam int SM_MAX_W = 128;

  // Sign-magnitude word of width w (sign at bit w-1) to two's complement.
  function automatic logic signed [SM_MAX_W-1:0] sm_to_tc(input logic [SM_MAX_W-1:0] sm,
                                                          input int unsigned w);
    logic [SM_MAX_W-1:0]        mag;
    logic                       neg;
    logic signed [SM_MAX_W-1:0] r;
    mag = sm & ((SM_MAX_W'(1) << (w - 1)) - SM_MAX_W'(1));
    neg = ((sm >> (w - 1)) & SM_MAX_W'(1)) != '0;
    r   = signed'(mag);
    return neg ? -r : r;
  endfunction

  // Two's complement to sign-magnitude of width w, saturating the magnitude
  // to 2^(w-1)-1 and never producing negative zero.
  function automatic logic [SM_MAX_W-1:0] tc_to_sm_sat(input logic signed [SM_MAX_W-1:0] v,
                                                       input int unsigned w);
    logic [SM_MAX_W-1:0] mag;
    logic [SM_MAX_W-1:0] lim;
    logic                neg;
    neg = v[SM_MAX_W-1];
    mag = neg ? unsigned'(-v) : unsigned'(v);
    lim = (SM_MAX_W'(1) << (w - 1)) - SM_MAX_W'(1);
    if (mag > lim) mag = lim;
    if (mag == '0) neg = 1'b0;
    return neg ? (mag | (SM_MAX_W'(1) << (w - 1))) : mag;
  endfunction

endpackage

// File: rtl/neuron_mac_seq_if.sv
// Feature-in, weight-load and result-out signals of the MAC neuron.
interface neuron_mac_seq_if #(
  parameter int N_INPUTS = 4,
  parameter int Q_M      = 15,
  parameter int Q_N      = 16
);
  localparam int W  = 1 + Q_M + Q_N;
  localparam int AW = $clog2(N_INPUTS + 1);

  logic [N_INPUTS*W-1:0] x_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic                  w_we_i;
  logic [AW-1:0]         w_addr_i;
  logic [W-1:0]          w_data_i;
  logic                  w_busy_o;
  logic [W-1:0]          y_o;
  logic                  fire_o;
  logic                  out_valid_o;
  logic                  out_ready_i;

  // Neuron side.
  modport slave (
    input  x_i, in_valid_i, w_we_i, w_addr_i, w_data_i, out_ready_i,
    output in_ready_o, w_busy_o, y_o, fire_o, out_valid_o
  );

  // Feature source / weight loader / next layer side.
  modport master (
    output x_i, in_valid_i, w_we_i, w_addr_i, w_data_i, out_ready_i,
    input  in_ready_o, w_busy_o, y_o, fire_o, out_valid_o
  );
endinterface

// File: rtl/neuron_mac_seq_sm_mult.sv
// Combinational sign-magnitude fixed-point multiply, rescaled by Q_N and
// returned as a two's complement accumulator-width term.
module sm_mult #(
  parameter int Q_M   = 15,
  parameter int Q_N   = 16,
  parameter int ACC_W = 52
) (
  input  logic [Q_M+Q_N:0]        x_i,
  input  logic [Q_M+Q_N:0]        w_i,
  output logic signed [ACC_W-1:0] prod_o
);
  localparam int MW = Q_M + Q_N;

  logic [2*MW-1:0]         full;
  logic [2*MW-Q_N-1:0]     mag;
  logic signed [ACC_W-1:0] ext;
  logic                    neg;

  // Magnitude product truncated toward zero; a zero magnitude is never negated.
  always_comb begin
    full   = {{MW{1'b0}}, x_i[MW-1:0]} * {{MW{1'b0}}, w_i[MW-1:0]};
    mag    = full[2*MW-1:Q_N];
    ext    = signed'(ACC_W'(mag));
    neg    = (x_i[MW] ^ w_i[MW]) && (mag != '0);
    prod_o = neg ? -ext : ext;
  end
endmodule

// File: rtl/neuron_mac_seq.sv
// N-input perceptron: bias preload, one sign-magnitude MAC per cycle,
// then a step or ReLU activation presented on a valid/ready output.
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int Q_M      = 15,
  parameter int Q_N      = 16,
  parameter int ACT_MODE = 0
) (
  input logic             clk_i,
  input logic             rst_ni,
  neuron_mac_seq_if.slave bus
);
  localparam int W     = 1 + Q_M + Q_N;
  localparam int AW    = $clog2(N_INPUTS + 1);
  localparam int ACC_W = 2*Q_M + Q_N + 2 + AW;
  localparam logic [W-1:0] ONE = W'(1) << Q_N;

  state_e                  state_q, state_d;
  logic [W-1:0]            weights [0:N_INPUTS];
  logic [N_INPUTS*W-1:0]   x_q;
  logic [AW-1:0]           idx_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] prod;
  logic [W-1:0]            y_q;
  logic                    fire_q;
  logic                    out_valid_q;
  logic [W-1:0]            x_sel;
  logic [W-1:0]            w_sel;
  logic [W-1:0]            y_act;
  logic                    in_hs;
  logic                    out_hs;
  logic                    last_mac;
  logic                    acc_pos;

  assign in_hs    = (state_q == IDLE) && bus.in_valid_i;
  assign out_hs   = out_valid_q && bus.out_ready_i;
  assign last_mac = (idx_q == AW'(N_INPUTS - 1));
  assign acc_pos  = !acc_q[ACC_W-1] && (acc_q != '0);
  assign x_sel    = x_q[int'(idx_q)*W +: W];
  assign w_sel    = weights[idx_q];

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.w_busy_o    = (state_q != IDLE);
  assign bus.y_o         = y_q;
  assign bus.fire_o      = fire_q;
  assign bus.out_valid_o = out_valid_q;

  sm_mult #(.Q_M(Q_M), .Q_N(Q_N), .ACC_W(ACC_W)) u_mult (
    .x_i    (x_sel),
    .w_i    (w_sel),
    .prod_o (prod)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: capture, N MAC cycles, one activation cycle, hold until taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_hs)    state_d = MAC;
      MAC:  if (last_mac) state_d = ACT;
      ACT:                state_d = OUT;
      OUT:  if (out_hs)   state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // Weight store; writable only while idle, bias lives at address N_INPUTS.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i <= N_INPUTS; i++) weights[i] <= '0;
    end else if ((state_q == IDLE) && bus.w_we_i && (int'(bus.w_addr_i) <= N_INPUTS)) begin
      weights[bus.w_addr_i] <= bus.w_data_i;
    end
  end

  // Input capture and accumulator; the bias input is fixed at 1.0, so its product is WB itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q   <= '0;
      idx_q <= '0;
      acc_q <= '0;
    end else if (in_hs) begin
      x_q   <= bus.x_i;
      idx_q <= '0;
      acc_q <= ACC_W'(sm_to_tc(SM_MAX_W'(weights[N_INPUTS]), W));
    end else if (state_q == MAC) begin
      idx_q <= idx_q + AW'(1);
      acc_q <= acc_q + prod;
    end
  end

  // Activation function applied to the final accumulator.
  always_comb begin
    y_act = '0;
    if (acc_pos) begin
      if (ACT_MODE == ACT_RELU) y_act = W'(tc_to_sm_sat(SM_MAX_W'(acc_q), W));
      else                      y_act = ONE;
    end
  end

  // Result registers; valid rises one cycle after entering OUT and drops on the handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_q         <= '0;
      fire_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (state_q == ACT) begin
        y_q    <= y_act;
        fire_q <= acc_pos;
      end
      out_valid_q <= (state_q == OUT) && !out_hs;
    end
  end
endmodule
